// File: rtl/lif_neuron_core.sv
// Time-multiplexed leaky-integrate-and-fire neuron core.
// Each update runs DECAY, then N_INPUTS ACCUM cycles (one lane per cycle), then FIRE.
module lif_neuron_core #(
  parameter int unsigned N_INPUTS  = 4,
  parameter int unsigned N_NEURONS = 8,
  parameter int unsigned W         = 32,
  parameter int unsigned REFRACT_W = 4,
  localparam int unsigned NID_W    = $clog2(N_NEURONS)
) (
  input  logic                    CLK,
  input  logic                    RESET,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [NID_W-1:0]        in_neuron,
  input  logic [N_INPUTS-1:0]     spike_in,
  input  logic [N_INPUTS*W-1:0]   weight,
  input  logic [W-1:0]            v_threshold,
  input  logic [W-1:0]            v_reset,
  input  logic [2:0]              decay_rate,
  input  logic [REFRACT_W-1:0]    refract_cycles,
  output logic                    out_valid,
  output logic [NID_W-1:0]        out_neuron,
  output logic                    spiked,
  output logic [W-1:0]            potential_out
);

  localparam int unsigned LANE_W = (N_INPUTS > 1) ? $clog2(N_INPUTS) : 1;
  localparam logic [LANE_W-1:0] LAST_LANE = LANE_W'(N_INPUTS - 1);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_DECAY = 2'd1;
  localparam logic [1:0] S_ACCUM = 2'd2;
  localparam logic [1:0] S_FIRE  = 2'd3;

  localparam logic signed [W-1:0] SAT_MAX = {1'b0, {(W-1){1'b1}}};
  localparam logic signed [W-1:0] SAT_MIN = {1'b1, {(W-1){1'b0}}};

  // Control and datapath registers
  logic [1:0]               state_q, state_d;
  logic                     ready_q, ready_d;
  logic [LANE_W-1:0]        lane_q, lane_d;
  logic signed [W-1:0]      acc_q, acc_d;
  logic                     out_valid_q, out_valid_d;
  logic [NID_W-1:0]         out_nid_q, out_nid_d;
  logic                     spiked_q, spiked_d;
  logic [W-1:0]             pot_out_q, pot_out_d;

  // Request latched at acceptance
  logic [NID_W-1:0]                nid_q;
  logic [N_INPUTS-1:0]             spk_q;
  logic [N_INPUTS-1:0][W-1:0]      wgt_q;
  logic signed [W-1:0]             thr_q;
  logic [W-1:0]                    vrst_q;
  logic [2:0]                      dec_q;
  logic [REFRACT_W-1:0]            rcyc_q;
  logic                            refr_q;

  // Neuron store
  logic signed [W-1:0]     pot_q [N_NEURONS];
  logic [REFRACT_W-1:0]    rc_q  [N_NEURONS];

  logic                    accept_c;
  logic                    wr_en_c;
  logic [W-1:0]            wr_pot_c;
  logic [REFRACT_W-1:0]    wr_rc_c;
  logic signed [W-1:0]     p_rd_c;
  logic signed [W-1:0]     decayed_c;
  logic [W-1:0]            lane_w_c;
  logic [W:0]              sum_c;
  logic signed [W-1:0]     sat_c;

  assign in_ready      = ready_q;
  assign out_valid     = out_valid_q;
  assign out_neuron    = out_nid_q;
  assign spiked        = spiked_q;
  assign potential_out = pot_out_q;

  // Leak and saturating lane-add arithmetic
  always_comb begin
    p_rd_c    = pot_q[nid_q];
    decayed_c = (dec_q == 3'd0) ? p_rd_c : (p_rd_c - (p_rd_c >>> dec_q));
    lane_w_c  = wgt_q[lane_q];
    sum_c     = {acc_q[W-1], acc_q} + {lane_w_c[W-1], lane_w_c};
    if (sum_c[W] != sum_c[W-1]) begin
      sat_c = sum_c[W] ? SAT_MIN : SAT_MAX;
    end else begin
      sat_c = sum_c[W-1:0];
    end
  end

  // Next-state, accumulation and write-back decisions
  always_comb begin
    state_d     = state_q;
    lane_d      = lane_q;
    acc_d       = acc_q;
    out_valid_d = 1'b0;
    out_nid_d   = out_nid_q;
    spiked_d    = spiked_q;
    pot_out_d   = pot_out_q;
    accept_c    = 1'b0;
    wr_en_c     = 1'b0;
    wr_pot_c    = acc_q;
    wr_rc_c     = rc_q[nid_q];
    case (state_q)
      S_IDLE: begin
        if (in_valid && ready_q) begin
          accept_c = 1'b1;
          state_d  = S_DECAY;
        end
      end
      S_DECAY: begin
        acc_d   = decayed_c;
        lane_d  = '0;
        state_d = S_ACCUM;
      end
      S_ACCUM: begin
        if (spk_q[lane_q]) begin
          acc_d = sat_c;
        end
        if (lane_q == LAST_LANE) begin
          state_d = S_FIRE;
        end else begin
          lane_d = LANE_W'(lane_q + LANE_W'(1));
        end
      end
      S_FIRE: begin
        wr_en_c = 1'b1;
        if (refr_q) begin
          // Refractory: discard the accumulation and count down
          wr_pot_c = vrst_q;
          wr_rc_c  = REFRACT_W'(rc_q[nid_q] - REFRACT_W'(1));
          spiked_d = 1'b0;
        end else if (acc_q >= thr_q) begin
          wr_pot_c = vrst_q;
          wr_rc_c  = rcyc_q;
          spiked_d = 1'b1;
        end else begin
          wr_pot_c = acc_q;
          spiked_d = 1'b0;
        end
        out_valid_d = 1'b1;
        out_nid_d   = nid_q;
        pot_out_d   = wr_pot_c;
        state_d     = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
    ready_d = (state_d == S_IDLE);
  end

  // State and output registers
  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q     <= S_IDLE;
      ready_q     <= 1'b0;
      lane_q      <= '0;
      acc_q       <= '0;
      out_valid_q <= 1'b0;
      out_nid_q   <= '0;
      spiked_q    <= 1'b0;
      pot_out_q   <= '0;
    end else begin
      state_q     <= state_d;
      ready_q     <= ready_d;
      lane_q      <= lane_d;
      acc_q       <= acc_d;
      out_valid_q <= out_valid_d;
      out_nid_q   <= out_nid_d;
      spiked_q    <= spiked_d;
      pot_out_q   <= pot_out_d;
    end
  end

  // Capture request and config on acceptance
  always_ff @(posedge CLK) begin
    if (RESET) begin
      nid_q  <= '0;
      spk_q  <= '0;
      wgt_q  <= '0;
      thr_q  <= '0;
      vrst_q <= '0;
      dec_q  <= '0;
      rcyc_q <= '0;
      refr_q <= 1'b0;
    end else if (accept_c) begin
      nid_q  <= in_neuron;
      spk_q  <= spike_in;
      wgt_q  <= weight;
      thr_q  <= v_threshold;
      vrst_q <= v_reset;
      dec_q  <= decay_rate;
      rcyc_q <= refract_cycles;
      refr_q <= (rc_q[in_neuron] != '0);
    end
  end

  // Neuron store write-back on the FIRE edge
  always_ff @(posedge CLK) begin
    if (RESET) begin
      for (int i = 0; i < int'(N_NEURONS); i++) begin
        pot_q[i] <= '0;
        rc_q[i]  <= '0;
      end
    end else if (wr_en_c) begin
      pot_q[nid_q] <= wr_pot_c;
      rc_q[nid_q]  <= wr_rc_c;
    end
  end

endmodule

// File: tb/tb_lif_neuron_core.sv
// Scoreboard bench for lif_neuron_core: a behavioural model predicts each
// update when it is driven; outputs are popped and compared on out_valid.
module tb_lif_neuron_core;

  localparam int N_IN = 4;
  localparam int NN   = 8;
  localparam int W    = 32;
  localparam int RW   = 4;
  localparam int LAT  = N_IN + 2;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              in_valid = 1'b0;
  logic              in_ready;
  logic [2:0]        in_neuron = '0;
  logic [N_IN-1:0]   spike_in = '0;
  logic [N_IN*W-1:0] weight = '0;
  logic [W-1:0]      v_threshold = '0;
  logic [W-1:0]      v_reset = '0;
  logic [2:0]        decay_rate = '0;
  logic [RW-1:0]     refract_cycles = '0;
  logic              out_valid;
  logic [2:0]        out_neuron;
  logic              spiked;
  logic [W-1:0]      potential_out;

  int errors = 0;
  int checks = 0;

  typedef struct {
    int          nid;
    bit          sp;
    logic [31:0] pot;
  } exp_t;

  exp_t   sb[$];
  longint mpot[NN];
  int     mrc[NN];

  lif_neuron_core #(
    .N_INPUTS(N_IN), .N_NEURONS(NN), .W(W), .REFRACT_W(RW)
  ) dut (
    .CLK(clk), .RESET(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_neuron(in_neuron),
    .spike_in(spike_in), .weight(weight), .v_threshold(v_threshold),
    .v_reset(v_reset), .decay_rate(decay_rate), .refract_cycles(refract_cycles),
    .out_valid(out_valid), .out_neuron(out_neuron), .spiked(spiked),
    .potential_out(potential_out)
  );

  always #5 clk = ~clk;

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time exceeded");
    $fatal(1, "watchdog");
  end

  function automatic logic [N_IN*W-1:0] pack4(input logic [31:0] a, b, c, d);
    return {d, c, b, a};
  endfunction

  task automatic model_clear();
    for (int i = 0; i < NN; i++) begin
      mpot[i] = 0;
      mrc[i]  = 0;
    end
  endtask

  // Behavioural LIF model; pushes the expected output for one request
  task automatic predict(input int n, input logic [3:0] spk, input logic [N_IN*W-1:0] wts,
                         input logic [31:0] thr, input logic [31:0] vr, input int dec, input int rc);
    longint p;
    longint acc;
    exp_t   e;
    e.nid = n;
    if (mrc[n] != 0) begin
      e.sp    = 1'b0;
      e.pot   = vr;
      mrc[n]  = mrc[n] - 1;
      mpot[n] = longint'($signed(vr));
    end else begin
      p = mpot[n];
      if (dec != 0) p = p - (p >>> dec);
      acc = p;
      for (int i = 0; i < N_IN; i++) begin
        if (spk[i]) begin
          acc = acc + longint'($signed(wts[i*32 +: 32]));
          if (acc > 64'sd2147483647) acc = 64'sd2147483647;
          if (acc < -64'sd2147483648) acc = -64'sd2147483648;
        end
      end
      if (acc >= longint'($signed(thr))) begin
        e.sp    = 1'b1;
        e.pot   = vr;
        mrc[n]  = rc;
        mpot[n] = longint'($signed(vr));
      end else begin
        e.sp    = 1'b0;
        e.pot   = 32'(acc);
        mpot[n] = acc;
      end
    end
    sb.push_back(e);
  endtask

  task automatic drive(input int n, input logic [3:0] spk, input logic [N_IN*W-1:0] wts,
                       input logic [31:0] thr, input logic [31:0] vr, input int dec, input int rc);
    in_neuron      = 3'(n);
    spike_in       = spk;
    weight         = wts;
    v_threshold    = thr;
    v_reset        = vr;
    decay_rate     = 3'(dec);
    refract_cycles = RW'(rc);
    in_valid       = 1'b1;
  endtask

  // Change every request input after acceptance; the core must ignore it
  task automatic scramble();
    in_valid       = 1'b0;
    in_neuron      = 3'($urandom);
    spike_in       = 4'($urandom);
    weight         = {$urandom, $urandom, $urandom, $urandom};
    v_threshold    = $urandom;
    v_reset        = $urandom;
    decay_rate     = 3'($urandom);
    refract_cycles = RW'($urandom);
  endtask

  // From a negedge: wait for in_ready, take the acceptance edge, return on the next negedge
  task automatic wait_accept(output bit ok);
    int t = 0;
    while (!in_ready && t < 40) begin
      @(negedge clk);
      t++;
    end
    checks++;
    if (!in_ready) begin
      errors++;
      $display("FAIL accept_timeout: in_ready=%0b required 1", in_ready);
      ok = 1'b0;
    end else begin
      ok = 1'b1;
      @(posedge clk);
      @(negedge clk);
    end
  endtask

  // Current negedge reflects the acceptance edge; wait for out_valid and score it
  task automatic collect(input string name);
    int   k = 0;
    exp_t e;
    while (!out_valid && k < 20) begin
      @(negedge clk);
      k++;
    end
    checks++;
    if (!out_valid) begin
      errors++;
      $display("FAIL %s_timeout: out_valid=%0b required 1", name, out_valid);
      return;
    end
    checks++;
    if (k != LAT) begin
      errors++;
      $display("FAIL %s_latency: got %0d edges required %0d", name, k, LAT);
    end
    checks++;
    if (sb.size() == 0) begin
      errors++;
      $display("FAIL %s_unexpected: output with empty scoreboard", name);
    end else begin
      e = sb.pop_front();
      if (out_neuron !== 3'(e.nid)) begin
        errors++;
        $display("FAIL %s_neuron: got %0d required %0d", name, out_neuron, e.nid);
      end
      checks++;
      if (spiked !== e.sp) begin
        errors++;
        $display("FAIL %s_spiked: got %0b required %0b", name, spiked, e.sp);
      end
      checks++;
      if (potential_out !== e.pot) begin
        errors++;
        $display("FAIL %s_potential: got 0x%08h required 0x%08h", name, potential_out, e.pot);
      end
    end
    checks++;
    if (in_ready !== 1'b1) begin
      errors++;
      $display("FAIL %s_ready_with_valid: got %0b required 1", name, in_ready);
    end
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b0) begin
      errors++;
      $display("FAIL %s_pulse: out_valid got %0b required 0", name, out_valid);
    end
  endtask

  task automatic send(input string name, input int n, input logic [3:0] spk,
                      input logic [N_IN*W-1:0] wts, input logic [31:0] thr,
                      input logic [31:0] vr, input int dec, input int rc);
    bit ok;
    drive(n, spk, wts, thr, vr, dec, rc);
    predict(n, spk, wts, thr, vr, dec, rc);
    wait_accept(ok);
    if (ok) begin
      scramble();
      collect(name);
    end else begin
      void'(sb.pop_back());
      in_valid = 1'b0;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    checks++;
    if (in_ready !== 1'b0) begin
      errors++;
      $display("FAIL reset_ready: got %0b required 0", in_ready);
    end
    checks++;
    if ({out_valid, spiked, out_neuron, potential_out} !== '0) begin
      errors++;
      $display("FAIL reset_outputs: got v=%0b s=%0b n=%0d p=0x%08h required all 0",
               out_valid, spiked, out_neuron, potential_out);
    end
    rst = 1'b0;
    model_clear();
    @(negedge clk);
    checks++;
    if (in_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_ready_after: got %0b required 1", in_ready);
    end
  endtask

  task automatic test_basic();
    send("basic", 0, 4'b1011, pack4(10, 20, 30, 40), 100, 0, 0, 0);
  endtask

  task automatic test_decay_fire();
    send("decay_fire", 0, 4'b1111, pack4(20, 20, 20, 20), 100, 0, 1, 2);
  endtask

  task automatic test_refractory();
    for (int i = 0; i < 3; i++) begin
      send($sformatf("refract%0d", i), 0, 4'b1111, pack4(20, 20, 20, 20), 100, 0, 0, 2);
    end
  endtask

  task automatic test_isolation();
    send("iso_n3", 3, 4'b0001, pack4(50, 0, 0, 0), 100, 0, 0, 0);
    send("iso_n0", 0, 4'b0000, pack4(7, 7, 7, 7), 100, 0, 0, 0);
  endtask

  task automatic test_saturation();
    send("sat_neg", 5, 4'b1111, pack4(32'h80000001, 32'h80000001, 32'h80000001, 32'h80000001),
         100, 0, 0, 0);
    send("sat_pos", 5, 4'b1111, pack4(32'h7FFFFFFF, 32'h7FFFFFFF, 32'h7FFFFFFF, 32'h7FFFFFFF),
         32'h7FFFFFFF, 32'h0000_0011, 0, 0);
  endtask

  // Second request held on in_valid while the first runs; taken N_IN+3 edges later
  task automatic test_back_to_back();
    bit ok;
    drive(1, 4'b0101, pack4(-5, 9, 12, 3), 1000, 0, 0, 0);
    predict(1, 4'b0101, pack4(-5, 9, 12, 3), 1000, 0, 0, 0);
    wait_accept(ok);
    if (!ok) begin
      in_valid = 1'b0;
      return;
    end
    drive(0, 4'b0010, pack4(1, -100, 1, 1), 50, 0, 3, 0);
    predict(0, 4'b0010, pack4(1, -100, 1, 1), 50, 0, 3, 0);
    checks++;
    if (in_ready !== 1'b0) begin
      errors++;
      $display("FAIL b2b_busy_ready: got %0b required 0", in_ready);
    end
    collect("b2b_first");
    scramble();
    collect("b2b_second");
  endtask

  task automatic test_reset_abort();
    bit ok;
    send("abort_pre", 2, 4'b0001, pack4(33, 0, 0, 0), 1000, 0, 0, 0);
    drive(2, 4'b1111, pack4(5, 5, 5, 5), 1000, 0, 0, 0);
    wait_accept(ok);
    if (!ok) begin
      in_valid = 1'b0;
      return;
    end
    repeat (3) @(negedge clk);
    checks++;
    if (in_ready !== 1'b0 || out_valid !== 1'b0) begin
      errors++;
      $display("FAIL abort_busy: in_ready=%0b out_valid=%0b required 0 0", in_ready, out_valid);
    end
    rst = 1'b1;
    @(negedge clk);
    checks++;
    if (in_ready !== 1'b0 || out_valid !== 1'b0) begin
      errors++;
      $display("FAIL abort_in_reset: in_ready=%0b out_valid=%0b required 0 0", in_ready, out_valid);
    end
    rst = 1'b0;
    model_clear();
    predict(2, 4'b1111, pack4(5, 5, 5, 5), 1000, 0, 0, 0);
    wait_accept(ok);
    if (ok) begin
      scramble();
      collect("abort_retry");
    end else begin
      in_valid = 1'b0;
    end
  endtask

  initial begin
    model_clear();
    test_reset();
    test_basic();
    test_decay_fire();
    test_refractory();
    test_isolation();
    test_saturation();
    test_back_to_back();
    test_reset_abort();
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: %0d outputs missing, required 0", sb.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
